// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU command issuer: opcodes, FSM encoding, default width.
package alu_pkg;

    localparam int ALU_W = 4;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_PASSB = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_mul(input logic [2:0] op);
        return op == OP_MUL;
    endfunction

endpackage

// File: rtl/alu_comb_slice.sv
// Combinational W-bit ALU for every opcode except multiply; operands are zero-extended to 2*W.
module alu_comb_slice
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [2:0]     op,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] y
);

    logic [2*W-1:0] ax;
    logic [2*W-1:0] bx;

    assign ax = {{W{1'b0}}, a};
    assign bx = {{W{1'b0}}, b};

    always_comb begin
        y = '0;
        case (op)
            OP_ADD:   y = ax + bx;
            OP_SUB:   y = ax - bx;
            OP_AND:   y = ax & bx;
            OP_OR:    y = ax | bx;
            OP_PASSA: y = ax;
            OP_PASSB: y = bx;
            OP_XOR:   y = ax ^ bx;
            // Multiply runs iteratively in the issuer; this slice never produces it.
            default:  y = '0;
        endcase
    end

endmodule

// File: rtl/alu_seq_issuer.sv
// Command front end for the ALU: single-cycle ops via alu_comb_slice, shift-add multiply.
// Optional macro ALU_ACC_EN adds cmd_use_acc to chain on the previous result.
module alu_seq_issuer
    import alu_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [2:0]     cmd_op,
`ifdef ALU_ACC_EN
    input  logic           cmd_use_acc,
`endif
    input  logic [W-1:0]   cmd_a,
    input  logic [W-1:0]   cmd_b,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_y,
    output logic           res_zero,
    output logic           busy
);

    // Handshakes: a command transfers on a rising edge where cmd_valid & cmd_ready;
    // a result transfers where res_valid & res_ready. Valid must not depend on ready,
    // and a producer holds its payload stable until the transfer edge.

    localparam int CW = $clog2(W) + 1;

    state_t         state;
    state_t         state_next;
    logic           accept;
    logic           mul_last;
    logic [W-1:0]   op_a;
    logic [2*W-1:0] slice_y;

    logic [2*W-1:0] acc;
    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;
    logic [2*W-1:0] acc_sum;

    // Visible FSM state for hierarchical checkers.
    state_t         dbg_state;
    assign dbg_state = state;

`ifdef ALU_ACC_EN
    // res_y only updates on completion, so its low half is the latest finished result.
    assign op_a = cmd_use_acc ? res_y[W-1:0] : cmd_a;
`else
    assign op_a = cmd_a;
`endif

    alu_comb_slice #(.W(W)) u_slice (
        .op (cmd_op),
        .a  (op_a),
        .b  (cmd_b),
        .y  (slice_y)
    );

    assign acc_sum = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        cmd_ready  = 1'b0;
        accept     = 1'b0;
        mul_last   = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                accept    = cmd_valid;
                if (accept) begin
                    state_next = is_mul(cmd_op) ? ST_MUL : ST_DONE;
                end
            end
            ST_MUL: begin
                mul_last = (cnt == CW'(W - 1));
                if (mul_last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                cmd_ready = res_ready;
                accept    = cmd_valid & res_ready;
                if (accept) begin
                    state_next = is_mul(cmd_op) ? ST_MUL : ST_DONE;
                end else if (res_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign res_valid = (state == ST_DONE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_y    <= '0;
            res_zero <= 1'b0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
        end else if (accept) begin
            if (is_mul(cmd_op)) begin
                acc    <= '0;
                mcand  <= {{W{1'b0}}, op_a};
                mplier <= cmd_b;
                cnt    <= '0;
            end else begin
                res_y    <= slice_y;
                res_zero <= (slice_y == '0);
            end
        end else if (state == ST_MUL) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (mul_last) begin
                res_y    <= acc_sum;
                res_zero <= (acc_sum == '0);
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_issuer.sv
// Directed bench for alu_seq_issuer; define ALU_ACC_EN to also exercise chained operands.
module tb_alu_seq_issuer;
    import alu_pkg::*;

    localparam int W = 4;

    logic           clk;
    logic           rst_n;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [2:0]     cmd_op;
`ifdef ALU_ACC_EN
    logic           cmd_use_acc;
`endif
    logic [W-1:0]   cmd_a;
    logic [W-1:0]   cmd_b;
    logic           res_valid;
    logic           res_ready;
    logic [2*W-1:0] res_y;
    logic           res_zero;
    logic           busy;

    int n_pass = 0;
    int n_total = 0;

    alu_seq_issuer #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
`ifdef ALU_ACC_EN
        .cmd_use_acc (cmd_use_acc),
`endif
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_y       (res_y),
        .res_zero    (res_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic v, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b);
        cmd_valid = v;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
`ifdef ALU_ACC_EN
        cmd_use_acc = 1'b0;
`endif
    endtask

    // One single-cycle op from IDLE, checked one cycle after accept, then drained.
    task automatic do_single(input string tag, input logic [2:0] op,
                             input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [7:0] exp_y);
        res_ready = 1'b0;
        drive_cmd(1'b1, op, a, b);
        #1;
        chk({tag, "_rdy"}, cmd_ready, 1'b1);
        step();
        drive_cmd(1'b0, OP_ADD, 4'h0, 4'h0);
        #1;
        chk({tag, "_valid"}, res_valid, 1'b1);
        chk({tag, "_y"}, res_y, exp_y);
        chk({tag, "_zero"}, res_zero, exp_y == 8'h00);
        chk({tag, "_rdy_bp"}, cmd_ready, 1'b0);
        res_ready = 1'b1;
        #1;
        chk({tag, "_rdy_done"}, cmd_ready, 1'b1);
        step();
        res_ready = 1'b0;
        #1;
        chk({tag, "_idle_valid"}, res_valid, 1'b0);
        chk({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    // Multiply from IDLE; res_ready is held high during MUL to confirm it is ignored.
    task automatic do_mul(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [7:0] exp_y);
        res_ready = 1'b0;
        drive_cmd(1'b1, OP_MUL, a, b);
        step();
        drive_cmd(1'b0, OP_ADD, 4'h0, 4'h0);
        res_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk($sformatf("%s_mul_valid_c%0d", tag, k), res_valid, 1'b0);
            chk($sformatf("%s_mul_rdy_c%0d", tag, k), cmd_ready, 1'b0);
            chk($sformatf("%s_mul_busy_c%0d", tag, k), busy, 1'b1);
            step();
        end
        #1;
        chk({tag, "_valid_c5"}, res_valid, 1'b1);
        chk({tag, "_y"}, res_y, exp_y);
        chk({tag, "_zero"}, res_zero, exp_y == 8'h00);
        step();
        res_ready = 1'b0;
        #1;
        chk({tag, "_idle_valid"}, res_valid, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        res_ready = 1'b0;
        drive_cmd(1'b0, OP_ADD, 4'h0, 4'h0);
        step();
        step();
        chk("rst_valid", res_valid, 1'b0);
        chk("rst_y", res_y, 8'h00);
        chk("rst_zero", res_zero, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        step();
        chk("rst_cmd_ready", cmd_ready, 1'b1);

        do_single("add", OP_ADD,   4'h9, 4'h8, 8'h11);
        do_single("sub", OP_SUB,   4'h3, 4'h5, 8'hFE);
        do_single("xor", OP_XOR,   4'hA, 4'h5, 8'h0F);
        do_single("passb", OP_PASSB, 4'h3, 4'hC, 8'h0C);
        do_single("passa", OP_PASSA, 4'h7, 4'hC, 8'h07);
        do_single("addmax", OP_ADD, 4'hF, 4'hF, 8'h1E);

        // Backpressure on and, with the next (or) command already waiting.
        drive_cmd(1'b1, OP_AND, 4'h6, 4'h3);
        step();
        drive_cmd(1'b1, OP_OR, 4'h1, 4'h8);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("bp_valid_c%0d", k), res_valid, 1'b1);
            chk($sformatf("bp_y_c%0d", k), res_y, 8'h02);
            chk($sformatf("bp_rdy_c%0d", k), cmd_ready, 1'b0);
            step();
        end
        res_ready = 1'b1;
        #1;
        chk("b2b_rdy", cmd_ready, 1'b1);
        step();
        drive_cmd(1'b0, OP_ADD, 4'h0, 4'h0);
        #1;
        chk("b2b_valid", res_valid, 1'b1);
        chk("b2b_y", res_y, 8'h09);
        step();
        res_ready = 1'b0;
        #1;
        chk("b2b_idle", busy, 1'b0);

        do_mul("mul_ff", 4'hF, 4'hF, 8'hE1);
        do_mul("mul_0x9", 4'h0, 4'h9, 8'h00);
        do_mul("mul_7x9", 4'h7, 4'h9, 8'h3F);

        // Reset in the middle of a multiply: nothing may survive it.
        drive_cmd(1'b1, OP_MUL, 4'h7, 4'h9);
        step();
        drive_cmd(1'b0, OP_ADD, 4'h0, 4'h0);
        step();
        chk("mrst_busy_before", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", res_valid, 1'b0);
        chk("mrst_y", res_y, 8'h00);
        chk("mrst_busy", busy, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk("mrst_cmd_ready", cmd_ready, 1'b1);
        for (int k = 0; k < 6; k++) begin
            step();
            chk($sformatf("mrst_no_stale_c%0d", k), res_valid, 1'b0);
        end

`ifdef ALU_ACC_EN
        do_single("acc_seed", OP_ADD, 4'h4, 4'h3, 8'h07);
        res_ready   = 1'b0;
        drive_cmd(1'b1, OP_ADD, 4'hF, 4'h2);
        cmd_use_acc = 1'b1;
        step();
        drive_cmd(1'b0, OP_ADD, 4'h0, 4'h0);
        #1;
        chk("acc_valid", res_valid, 1'b1);
        chk("acc_y", res_y, 8'h09);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
